// File: rtl/dp_note_seq.sv
// Note sequencer: fetches score words from ROM, plays each as a square wave, pulses add to advance.
// Optional macro NOTE_GAP_EN silences the last 1/8 of each note's final beat tick.
module dp_note_seq #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned BEAT_HZ = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       restart,
    input  logic [7:0] rom_data,
    output logic       add,
    output logic       buzz,
    output logic       busy,
    output logic       song_end
);
    localparam int unsigned TICK_CYC = CLK_HZ / BEAT_HZ;
    localparam int unsigned MAX_HP   = CLK_HZ / (2 * 262);
    localparam int unsigned HP_W     = $clog2(MAX_HP) + 1;
    localparam int unsigned BEAT_W   = $clog2(TICK_CYC) + 1;
    localparam int unsigned FETCH_W  = $clog2(ROM_LAT + 2) + 1;
    localparam int unsigned GAP_CYC  = TICK_CYC / 8;

    typedef enum logic [2:0] {IDLE, FETCH, PLAY, ADV, DONE} state_e;

    state_e              state_q, state_d;
    logic [FETCH_W-1:0]  fetch_q, fetch_d;
    logic [3:0]          tone_q, tone_d;
    logic [3:0]          dur_q, dur_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
    logic                phase_q, phase_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          tick_q, tick_d;
    logic                add_q, add_d;
    logic                buzz_q, buzz_d;
    logic                busy_q, busy_d;
    logic                song_end_q, song_end_d;
    logic                gap;
    logic [3:0]          rom_tone;
    logic [3:0]          rom_dur;

    assign rom_tone = rom_data[7:4];
    assign rom_dur  = rom_data[3:0];

    // Half-period in sysclk cycles for each tone index, folded at elaboration.
    function automatic logic [HP_W-1:0] half_period(input logic [3:0] idx);
        case (idx)
            4'd1:    half_period = HP_W'(CLK_HZ / (2 * 262));
            4'd2:    half_period = HP_W'(CLK_HZ / (2 * 294));
            4'd3:    half_period = HP_W'(CLK_HZ / (2 * 330));
            4'd4:    half_period = HP_W'(CLK_HZ / (2 * 349));
            4'd5:    half_period = HP_W'(CLK_HZ / (2 * 392));
            4'd6:    half_period = HP_W'(CLK_HZ / (2 * 440));
            4'd7:    half_period = HP_W'(CLK_HZ / (2 * 494));
            4'd8:    half_period = HP_W'(CLK_HZ / (2 * 523));
            4'd9:    half_period = HP_W'(CLK_HZ / (2 * 587));
            4'd10:   half_period = HP_W'(CLK_HZ / (2 * 659));
            4'd11:   half_period = HP_W'(CLK_HZ / (2 * 698));
            4'd12:   half_period = HP_W'(CLK_HZ / (2 * 784));
            4'd13:   half_period = HP_W'(CLK_HZ / (2 * 880));
            4'd14:   half_period = HP_W'(CLK_HZ / (2 * 988));
            default: half_period = HP_W'(MAX_HP);
        endcase
    endfunction

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_q    <= '0;
            tone_q     <= '0;
            dur_q      <= '0;
            hp_q       <= '0;
            hp_cnt_q   <= '0;
            phase_q    <= 1'b0;
            beat_q     <= '0;
            tick_q     <= '0;
            add_q      <= 1'b0;
            buzz_q     <= 1'b0;
            busy_q     <= 1'b0;
            song_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_q    <= fetch_d;
            tone_q     <= tone_d;
            dur_q      <= dur_d;
            hp_q       <= hp_d;
            hp_cnt_q   <= hp_cnt_d;
            phase_q    <= phase_d;
            beat_q     <= beat_d;
            tick_q     <= tick_d;
            add_q      <= add_d;
            buzz_q     <= buzz_d;
            busy_q     <= busy_d;
            song_end_q <= song_end_d;
        end
    end

    // Next-state and counters; restart wins over everything, play=0 freezes all.
    always_comb begin
        state_d  = state_q;
        fetch_d  = fetch_q;
        tone_d   = tone_q;
        dur_d    = dur_q;
        hp_d     = hp_q;
        hp_cnt_d = hp_cnt_q;
        phase_d  = phase_q;
        beat_d   = beat_q;
        tick_d   = tick_q;
        add_d    = 1'b0;

        if (restart) begin
            state_d  = FETCH;
            fetch_d  = '0;
            hp_cnt_d = '0;
            phase_d  = 1'b0;
            beat_d   = '0;
            tick_d   = '0;
        end else if (play) begin
            case (state_q)
                FETCH: begin
                    if (fetch_q == FETCH_W'(ROM_LAT + 1)) begin
                        fetch_d = '0;
                        if (rom_tone == 4'hF) begin
                            state_d = DONE;
                        end else begin
                            state_d  = PLAY;
                            tone_d   = rom_tone;
                            dur_d    = (rom_dur == 4'd0) ? 4'd1 : rom_dur;
                            hp_d     = half_period(rom_tone);
                            hp_cnt_d = '0;
                            phase_d  = 1'b0;
                            beat_d   = '0;
                            tick_d   = '0;
                        end
                    end else begin
                        fetch_d = fetch_q + FETCH_W'(1);
                    end
                end
                PLAY: begin
                    if (hp_cnt_q == hp_q - HP_W'(1)) begin
                        hp_cnt_d = '0;
                        phase_d  = ~phase_q;
                    end else begin
                        hp_cnt_d = hp_cnt_q + HP_W'(1);
                    end
                    if (beat_q == BEAT_W'(TICK_CYC - 1)) begin
                        beat_d = '0;
                        if (tick_q == dur_q - 4'd1) begin
                            state_d = ADV;
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                ADV: begin
                    add_d   = 1'b1;
                    state_d = FETCH;
                    fetch_d = '0;
                end
                default: ;
            endcase
        end

`ifdef NOTE_GAP_EN
        gap = (tick_d == dur_d - 4'd1) && (beat_d >= BEAT_W'(TICK_CYC - GAP_CYC));
`else
        gap = 1'b0;
`endif

        buzz_d     = (state_d == PLAY) && play && !restart && (tone_d != 4'd0) && phase_d && !gap;
        busy_d     = (state_d == FETCH) || (state_d == PLAY) || (state_d == ADV);
        song_end_d = (state_d == DONE);
    end

    assign add      = add_q;
    assign buzz     = buzz_q;
    assign busy     = busy_q;
    assign song_end = song_end_q;
endmodule

// File: tb/tb_dp_note_seq.sv
// Bench for dp_note_seq: random and directed songs, scoreboarded per note (add spacing, buzz-high cycles).
`timescale 1ns/1ps
module tb_dp_note_seq;
    localparam int CLK_HZ  = 100000;
    localparam int BEAT_HZ = 100;
    localparam int ROM_LAT = 1;
    localparam int TICK    = CLK_HZ / BEAT_HZ;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b1;
    logic       play    = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] rom_data = 8'hF0;
    logic       add, buzz, busy, song_end;

    dp_note_seq #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .ROM_LAT(ROM_LAT)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .play(play), .restart(restart),
        .rom_data(rom_data), .add(add), .buzz(buzz), .busy(busy), .song_end(song_end)
    );

    always #5 sysclk = ~sysclk;

    // Score ROM (1-cycle latency) and the upstream address counter (add has priority over load).
    logic [7:0] rom [16];
    logic [3:0] addr = 4'd0;
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)       addr <= 4'd0;
        else if (add)     addr <= addr + 4'd1;
        else if (restart) addr <= 4'd0;
    end
    always @(posedge sysclk) rom_data <= rom[addr];

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        bit is_end;
        int interval;
        int hi;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int freq [15] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988};
    logic [7:0] song [16];
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int eff_dur(input logic [7:0] w);
        return (w[3:0] == 4'd0) ? 1 : int'(w[3:0]);
    endfunction

    // Reference: number of cycles the buzzer is high over one uninterrupted note.
    function automatic int note_hi(input logic [7:0] w);
        int tone = int'(w[7:4]);
        int len  = eff_dur(w) * TICK;
        int h, n;
        bit in_gap;
        n = 0;
        if (tone == 0) return 0;
        h = CLK_HZ / (2 * freq[tone]);
        for (int k = 0; k < len; k++) begin
`ifdef NOTE_GAP_EN
            in_gap = (k >= len - TICK / 8);
`else
            in_gap = 1'b0;
`endif
            if (((k / h) % 2) == 1 && !in_gap) n++;
        end
        return n;
    endfunction

    // Expected events after a restart: first add after 5+D*T cycles, then every D*T+4, end 3 after last add.
    task automatic push_song(input int n, input int pause_len);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (song[i][7:4] == 4'hF) begin
                e.is_end = 1'b1; e.interval = (i == 0) ? 4 : 3; e.hi = 0;
                sb.push_back(e);
                break;
            end
            e.is_end   = 1'b0;
            e.interval = eff_dur(song[i]) * TICK + ((i == 0) ? 5 + pause_len : 4);
            e.hi       = note_hi(song[i]);
            sb.push_back(e);
        end
    endtask

    task automatic start_song(input int n);
        for (int i = 0; i < 16; i++) rom[i] = (i < n) ? song[i] : 8'hF0;
        @(posedge sysclk); #1 restart = 1'b1;
        @(posedge sysclk); #1 restart = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_song_end", int'(song_end), 0);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!song_end && t < 40000) begin
            @(negedge sysclk);
            t++;
        end
        chk("end_reached", int'(song_end), 1);
        repeat (20) @(negedge sysclk);
    endtask

    // Monitor: pops one expectation per add pulse and per song_end rise.
    int ref_cyc = 0;
    int hi_cnt  = 0;
    bit end_prev  = 1'b0;
    bit play_prev = 1'b1;
    exp_t m;
    always @(negedge sysclk) begin
        if (mon_en) begin
            if (!play_prev) chk("pause_buzz", int'(buzz), 0);
            if (restart) begin
                ref_cyc = cyc;
                hi_cnt  = 0;
            end else begin
                if (buzz) hi_cnt++;
                if (add) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_add", 1, 0);
                    end else begin
                        m = sb.pop_front();
                        chk("add_not_end", int'(m.is_end), 0);
                        chk("add_interval", cyc - ref_cyc, m.interval);
                        chk("note_buzz_hi", hi_cnt, m.hi);
                    end
                    ref_cyc = cyc;
                    hi_cnt  = 0;
                end
                if (song_end && !end_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        m = sb.pop_front();
                        chk("end_is_end", int'(m.is_end), 1);
                        chk("end_interval", cyc - ref_cyc, m.interval);
                        chk("end_busy", int'(busy), 0);
                    end
                end
            end
            end_prev  = song_end;
            play_prev = play;
        end
    end

    initial begin
        int p_off, p_len;
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", int'({add, buzz, busy, song_end}), 0);
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        play   = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            chk("idle_outputs", int'({add, buzz, busy, song_end}), 0);
        end

        // Directed: tone 1 for 2 ticks, zero-duration rest, end marker.
        song[0] = 8'h12; song[1] = 8'h00; song[2] = 8'hF0;
        push_song(3, 0);
        start_song(3);
        wait_end();
        chk("done_song_end", int'(song_end), 1);
        chk("done_busy", int'(busy), 0);

        // Empty song: end marker at the first address.
        song[0] = 8'hF0;
        push_song(1, 0);
        start_song(1);
        wait_end();

        // Random songs; the second one is paused 500 cycles during its first note.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 3; i++)
                song[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3))};
            song[3] = 8'hF0;
            p_len = (s == 1) ? 500 : 0;
            p_off = $urandom_range(1, eff_dur(song[0]) * TICK + 4);
            push_song(4, p_len);
            start_song(4);
            if (p_len > 0) begin
                repeat (p_off - 1) @(posedge sysclk);
                #1 play = 1'b0;
                repeat (p_len) @(posedge sysclk);
                #1 play = 1'b1;
            end
            wait_end();
        end

        // Restart lands in the ADV cycle of the first note: its add must be suppressed.
        song[0] = 8'h31; song[1] = 8'h22; song[2] = 8'hF0;
        start_song(3);
        repeat (TICK + 3) @(posedge sysclk);
        #1 chk("pre_collision_add", int'(add), 0);
        push_song(3, 0);
        restart = 1'b1;
        @(posedge sysclk); #1 restart = 1'b0;
        chk("collision_add", int'(add), 0);
        chk("collision_busy", int'(busy), 1);
        chk("collision_buzz", int'(buzz), 0);
        wait_end();
        chk("sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a note.
        mon_en = 1'b0;
        song[0] = 8'h13; song[1] = 8'hF0;
        start_song(2);
        repeat (600) @(posedge sysclk);
        #1 chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_buzz", int'(buzz), (597 / (CLK_HZ / (2 * 262))) % 2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({add, buzz, busy, song_end}), 0);
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge sysclk);
            chk("post_reset_idle", int'({add, buzz, busy, song_end}), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
